// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-64 control unit: FSM states, opcodes and
// datapath mux select values.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExec,
      StRwb,
      StBranch,
      StJump,
      StTrap
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_B_RT     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_BR_OFS = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   // States that hold the shared memory port and so may stall on mem_ready
   function automatic logic is_mem_wait(state_e s);
      return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of memory stall cycles; flags the cycle on which a further stall would
// exceed the timeout budget.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);

   localparam logic [CNT_W-1:0] Limit  = CNT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = (MEM_TIMEOUT != 0) && en_i && (cnt_q == Limit);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS-64 control FSM: sequences fetch/decode/execute over a shared ALU and
// memory port, with memory handshake, bus timeout, illegal-opcode trap and retire pulse.
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned OPCODE_W    = 6,
   parameter int unsigned ALUOP_W     = 2,
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [OPCODE_W-1:0] opcode_i,
   input  logic                mem_ready_i,
   output logic                pc_write_o,
   output logic                pc_write_eq_o,
   output logic                pc_write_ne_o,
   output logic                ir_write_o,
   output logic                i_or_d_o,
   output logic                mem_read_o,
   output logic                mem_write_o,
   output logic                mem_to_reg_o,
   output logic                reg_dst_o,
   output logic                reg_write_o,
   output logic                alu_src_a_o,
   output logic [1:0]          alu_src_b_o,
   output logic [ALUOP_W-1:0]  alu_op_o,
   output logic [1:0]          pc_source_o,
   output logic                inst_done_o,
   output logic                illegal_op_o,
   output logic                bus_error_o
);

   state_e              state_q, state_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic                illegal_q, illegal_d;
   logic                bus_err_q, bus_err_d;
   logic                timeout;
   logic                wait_en;
   logic                wait_clr;

   assign wait_en  = is_mem_wait(state_q) && !mem_ready_i;
   assign wait_clr = (state_d != state_q);

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) u_mem_wait_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (wait_clr),
      .en_i     (wait_en),
      .timeout_o(timeout)
   );

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      illegal_d     = illegal_q;
      bus_err_d     = bus_err_q;
      pc_write_o    = 1'b0;
      pc_write_eq_o = 1'b0;
      pc_write_ne_o = 1'b0;
      ir_write_o    = 1'b0;
      i_or_d_o      = 1'b0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      mem_to_reg_o  = 1'b0;
      reg_dst_o     = 1'b0;
      reg_write_o   = 1'b0;
      alu_src_a_o   = 1'b0;
      alu_src_b_o   = SRC_B_RT;
      alu_op_o      = ALUOP_W'(ALU_OP_ADD);
      pc_source_o   = PC_SRC_ALU;
      inst_done_o   = 1'b0;
      // Outputs stay at their all-zero defaults while reset is held
      if (rst_ni) begin
         unique case (state_q)
            StFetch: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = SRC_B_FOUR;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
               if (mem_ready_i) begin
                  state_d = StDecode;
               end else if (timeout) begin
                  state_d   = StTrap;
                  bus_err_d = 1'b1;
               end
            end
            StDecode: begin
               alu_src_b_o = SRC_B_BR_OFS;
               op_d        = opcode_i;
               case (opcode_i)
                  OP_RTYPE, OP_ADDI: state_d = StExec;
                  OP_LW, OP_SW:      state_d = StMemAdr;
                  OP_BEQ, OP_BNE:    state_d = StBranch;
                  OP_J:              state_d = StJump;
                  default: begin
                     state_d   = StTrap;
                     illegal_d = 1'b1;
                  end
               endcase
            end
            StMemAdr: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = SRC_B_IMM;
               state_d     = (op_q == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
               mem_read_o = 1'b1;
               i_or_d_o   = 1'b1;
               if (mem_ready_i) begin
                  state_d = StMemWb;
               end else if (timeout) begin
                  state_d   = StTrap;
                  bus_err_d = 1'b1;
               end
            end
            StMemWb: begin
               reg_write_o  = 1'b1;
               mem_to_reg_o = 1'b1;
               inst_done_o  = 1'b1;
               state_d      = StFetch;
            end
            StMemWr: begin
               mem_write_o = 1'b1;
               i_or_d_o    = 1'b1;
               inst_done_o = mem_ready_i;
               if (mem_ready_i) begin
                  state_d = StFetch;
               end else if (timeout) begin
                  state_d   = StTrap;
                  bus_err_d = 1'b1;
               end
            end
            StExec: begin
               alu_src_a_o = 1'b1;
               if (op_q == OP_RTYPE) begin
                  alu_src_b_o = SRC_B_RT;
                  alu_op_o    = ALUOP_W'(ALU_OP_FUNCT);
               end else begin
                  alu_src_b_o = SRC_B_IMM;
               end
               state_d = StRwb;
            end
            StRwb: begin
               reg_write_o = 1'b1;
               reg_dst_o   = (op_q == OP_RTYPE);
               inst_done_o = 1'b1;
               state_d     = StFetch;
            end
            StBranch: begin
               alu_src_a_o   = 1'b1;
               alu_op_o      = ALUOP_W'(ALU_OP_SUB);
               pc_source_o   = PC_SRC_ALUOUT;
               pc_write_eq_o = (op_q == OP_BEQ);
               pc_write_ne_o = (op_q == OP_BNE);
               inst_done_o   = 1'b1;
               state_d       = StFetch;
            end
            StJump: begin
               pc_write_o  = 1'b1;
               pc_source_o = PC_SRC_JUMP;
               inst_done_o = 1'b1;
               state_d     = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StFetch;
         op_q      <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign illegal_op_o = illegal_q;
   assign bus_error_o  = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction sequences, trap, timeout and
// asynchronous reset, comparing the full output bundle every cycle.
module tb_multicycle_control_unit;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_eq, pc_write_ne, ir_write, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, inst_done, illegal_op, bus_error;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [19:0] outs;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   multicycle_control_unit #(
      .OPCODE_W   (6),
      .ALUOP_W    (2),
      .MEM_TIMEOUT(4),
      .CNT_W      (5)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .opcode_i     (opcode),
      .mem_ready_i  (mem_ready),
      .pc_write_o   (pc_write),
      .pc_write_eq_o(pc_write_eq),
      .pc_write_ne_o(pc_write_ne),
      .ir_write_o   (ir_write),
      .i_or_d_o     (i_or_d),
      .mem_read_o   (mem_read),
      .mem_write_o  (mem_write),
      .mem_to_reg_o (mem_to_reg),
      .reg_dst_o    (reg_dst),
      .reg_write_o  (reg_write),
      .alu_src_a_o  (alu_src_a),
      .alu_src_b_o  (alu_src_b),
      .alu_op_o     (alu_op),
      .pc_source_o  (pc_source),
      .inst_done_o  (inst_done),
      .illegal_op_o (illegal_op),
      .bus_error_o  (bus_error)
   );

   assign outs = {pc_write, pc_write_eq, pc_write_ne, ir_write, i_or_d, mem_read, mem_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                  inst_done, illegal_op, bus_error};

   function automatic logic [19:0] mk(input bit pcw, peq, pne, irw, iod, mrd, mwr, m2r, rdst,
                                      rw, sa, input bit [1:0] sb, aop, ps,
                                      input bit done, ill, berr);
      return {pcw, peq, pne, irw, iod, mrd, mwr, m2r, rdst, rw, sa, sb, aop, ps, done, ill, berr};
   endfunction

   //                            pcw eq ne ir iod rd wr m2r dst rw sa sb     aop    ps    dn il be
   localparam logic [19:0] E_Z   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_F0  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_F1  = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_D   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_EXR = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_EXI = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_RWR = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
   localparam logic [19:0] E_RWI = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
   localparam logic [19:0] E_MA  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_MR  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_WB  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
   localparam logic [19:0] E_MW0 = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
   localparam logic [19:0] E_MW1 = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0);
   localparam logic [19:0] E_BEQ = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0, 0);
   localparam logic [19:0] E_BNE = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0, 0);
   localparam logic [19:0] E_J   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0);
   localparam logic [19:0] E_TRI = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
   localparam logic [19:0] E_TRB = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);

   task automatic test_reset();
      rst_ni    = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      repeat (2) @(negedge clk_i);
      #1;
      checks++;
      if (outs !== E_Z) begin
         errors++;
         $display("FAIL reset_hold got %05h exp %05h", outs, E_Z);
      end
      @(negedge clk_i);
      rst_ni    = 1'b1;
      mem_ready = 1'b0;
      #1;
      checks++;
      if (outs !== E_F0) begin
         errors++;
         $display("FAIL reset_release got %05h exp %05h", outs, E_F0);
      end
   endtask

   task automatic test_rtype();
      logic [19:0] e [4] = '{E_F1, E_D, E_EXR, E_RWR};
      opcode = 6'b000000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         mem_ready = 1'b1;
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL rtype cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
   endtask

   task automatic test_addi();
      logic [19:0] e [4] = '{E_F1, E_D, E_EXI, E_RWI};
      opcode = 6'b001000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         mem_ready = 1'b1;
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL addi cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
   endtask

   task automatic test_lw();
      logic [19:0] e [8] = '{E_F1, E_D, E_MA, E_MR, E_MR, E_MR, E_MR, E_WB};
      bit          r [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
      opcode = 6'b100011;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         mem_ready = r[i];
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL lw cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
   endtask

   task automatic test_sw();
      logic [19:0] e [5] = '{E_F1, E_D, E_MA, E_MW0, E_MW1};
      bit          r [5] = '{1, 1, 1, 0, 1};
      opcode = 6'b101011;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         mem_ready = r[i];
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL sw cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
   endtask

   task automatic test_branch();
      logic [19:0] e  [6] = '{E_F1, E_D, E_BEQ, E_F1, E_D, E_BNE};
      logic [5:0]  op [6] = '{6'b000100, 6'b000100, 6'b000100, 6'b000101, 6'b000101, 6'b000101};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         mem_ready = 1'b1;
         opcode    = op[i];
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL branch cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
   endtask

   task automatic test_jump();
      logic [19:0] e [3] = '{E_F1, E_D, E_J};
      opcode = 6'b000010;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         mem_ready = 1'b1;
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL jump cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [19:0] e [5] = '{E_F1, E_D, E_TRI, E_TRI, E_TRI};
      bit          r [5] = '{1, 1, 1, 0, 1};
      opcode = 6'b111111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         mem_ready = r[i];
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL illegal cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
      @(negedge clk_i);
      rst_ni    = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checks++;
      if (outs !== E_F0) begin
         errors++;
         $display("FAIL illegal_cleared got %05h exp %05h", outs, E_F0);
      end
   endtask

   task automatic test_timeout();
      logic [19:0] e1 [5] = '{E_F0, E_F0, E_F0, E_TRB, E_TRB};
      logic [19:0] e2 [6] = '{E_F0, E_F0, E_F1, E_D, E_EXR, E_RWR};
      bit          r2 [6] = '{0, 0, 1, 1, 1, 1};
      opcode = 6'b000000;
      // Stall in FETCH: cycles 1..4 waiting, bus_error visible on cycle 5
      @(negedge clk_i);
      rst_ni    = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checks++;
      if (outs !== E_F0) begin
         errors++;
         $display("FAIL timeout_c1 got %05h exp %05h", outs, E_F0);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         mem_ready = 1'b0;
         #1;
         checks++;
         if (outs !== e1[i]) begin
            errors++;
            $display("FAIL timeout cyc %0d got %05h exp %05h", i + 2, outs, e1[i]);
         end
      end
      // Ready on the 4th stall cycle completes normally
      @(negedge clk_i);
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checks++;
      if (outs !== E_F0) begin
         errors++;
         $display("FAIL ready_wins_c1 got %05h exp %05h", outs, E_F0);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         mem_ready = r2[i];
         #1;
         checks++;
         if (outs !== e2[i]) begin
            errors++;
            $display("FAIL ready_wins cyc %0d got %05h exp %05h", i + 2, outs, e2[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [19:0] e [4] = '{E_F1, E_D, E_MA, E_MW0};
      bit          r [4] = '{1, 1, 1, 0};
      opcode = 6'b101011;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         mem_ready = r[i];
         #1;
         checks++;
         if (outs !== e[i]) begin
            errors++;
            $display("FAIL mid_reset cyc %0d got %05h exp %05h", i, outs, e[i]);
         end
      end
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if (outs !== E_Z) begin
         errors++;
         $display("FAIL mid_reset_async got %05h exp %05h", outs, E_Z);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      checks++;
      if (outs !== E_F0) begin
         errors++;
         $display("FAIL mid_reset_restart got %05h exp %05h", outs, E_F0);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_addi();
      test_lw();
      test_sw();
      test_branch();
      test_jump();
      test_illegal();
      test_timeout();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
